addsub_pipe: RTL and testbench
==============================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL have derived constant STAGES = WIDTH/4, the pipeline depth; one 4-bit lookahead slice per stage.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set on a, b, op is valid.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-010 out_valid  output  1  result on s, cout, ovf is valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 s  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned).
REQ-014 ovf  output  1  two's-complement signed overflow of the selected operation.

Function
REQ-015 Subtract SHALL be formed as a + ~b + 1; stage 0 carry-in = op, and every stage SHALL use b XOR op.
REQ-016 Stage k SHALL compute result bits [4k+3:4k] from a registered carry-in, using generate G = a&b and propagate P = a^b with full lookahead carries; ripple between bits within a slice is prohibited.
REQ-017 Each stage register SHALL hold a valid bit, the low result bits computed so far, the remaining unprocessed operand bits, the op-adjusted b bits, and the carry into the next slice.
REQ-018 Latency SHALL be exactly STAGES cycles: an operand accepted at edge N yields out_valid at edge N+STAGES when nothing stalls.
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-020 A transfer SHALL occur on a rising edge where valid and ready are both high, on the input and on the output side independently.
REQ-021 Stage k SHALL advance when it is empty or when stage k+1 advances. The final stage advances when out_ready is high or it is empty. in_ready SHALL equal the stage-0 advance condition, combinationally.
REQ-022 A stalled stage SHALL hold all its contents unchanged. Bubbles SHALL collapse: an empty stage accepts data even when a later stage is stalled.
REQ-023 s, cout, ovf SHALL be driven only from final-stage registers and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 ovf SHALL be the XOR of the carry into and the carry out of the MSB.
REQ-025 Simultaneous acceptance at stage 0 and emission at the final stage SHALL both take effect on the same edge with no loss or duplication.
REQ-026 Results SHALL emerge in acceptance order. in_valid with in_ready=0 SHALL NOT be captured. The producer holds a, b, op until acceptance.

Reset
REQ-027 While rst_n=0, all stage valid bits and out_valid SHALL be 0; s, cout, ovf SHALL be 0; in_ready SHALL be 1 from the first edge after deassertion.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; no result SHALL emerge for operands accepted before reset.
REQ-029 Only valid bits require reset; datapath registers MAY be reset for determinism, and outputs are defined as 0 under reset.

Structure
REQ-030 A shared package addsub_pkg SHALL hold the SLICE_W=4 constant and the stage-register struct typedef.
REQ-031 One sub-module cla_slice4 SHALL implement the combinational 4-bit lookahead slice (a, b, cin -> s, cout, carry into MSB), instantiated STAGES times via generate.
REQ-032 Top-level sequential logic SHALL be stage registers and handshake control only, with no further sub-modules.

Verification
REQ-033 With WIDTH=16 and out_ready=1, add 0x1234+0x4321 -> s=0x5555, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-034 Add 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1. Add 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0.
REQ-035 Subtract 0x0000-0x0001 -> s=0xFFFF, cout=0, ovf=0. Subtract 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-036 Issue 6 back-to-back operations with out_ready=0 -> exactly 4 accepted, then in_ready=0 and the outputs hold the first result. Raise out_ready -> all 6 results emerge in order on consecutive cycles.
REQ-037 Drop rst_n for one cycle while 3 operations are in flight -> out_valid=0, no stale results emerge, and a new 0x0001+0x0001 returns s=0x0002.
REQ-038 Run 10k random a, b, op with random in_valid/out_ready against a reference model -> zero mismatches, with order preserved.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and the pipeline stage-register layout for addsub_pipe.
// Struct fields are sized for the widest legal operand; narrower builds leave upper bits at zero.
package addsub_pkg;

    localparam int SLICE_W = 4;
    localparam int MAX_W   = 32;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] res;     // result bits produced by this and earlier slices
        logic [MAX_W-1:0] a_rem;   // unprocessed a bits, next slice at [3:0]
        logic [MAX_W-1:0] bx_rem;  // unprocessed op-adjusted b bits, next slice at [3:0]
        logic             carry;   // carry into the next slice
        logic             c_msb;   // carry into the top bit of this slice
    } stage_t;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: every carry is a flat sum of products of G, P and cin.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c_msb
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s     = p ^ {c[3], c[2], c[1], cin};
    assign cout  = c[4];
    assign c_msb = c[3];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one 4-bit lookahead slice per stage, valid/ready on both sides,
// per-stage stall with bubble collapse.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE_W;
    localparam int LAST   = STAGES - 1;

    stage_t            st  [STAGES];
    stage_t            nxt [STAGES];
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  bx;

    // Subtract is a + ~b + 1: invert b here, the +1 enters as stage-0 carry-in.
    assign bx = b ^ {WIDTH{op}};

    // A stage may load when it is empty or its occupant moves on this edge.
    always_comb begin : advance
        logic down;
        // NOTE: every always_comb output and temporary gets a value before any branch, so no latch can be inferred.
        down = out_ready;
        adv  = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = !st[k].valid || down;
            down   = adv[k];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE_W-1:0] sa, sb, ss;
        logic               sc, sco, scm;

        if (k == 0) begin : g_first
            assign sa     = a[SLICE_W-1:0];
            assign sb     = bx[SLICE_W-1:0];
            assign sc     = op;
            assign nxt[k] = '{valid:  in_valid,
                              res:    MAX_W'(ss),
                              a_rem:  MAX_W'(a) >> SLICE_W,
                              bx_rem: MAX_W'(bx) >> SLICE_W,
                              carry:  sco,
                              c_msb:  scm};
        end else begin : g_rest
            assign sa     = st[k-1].a_rem[SLICE_W-1:0];
            assign sb     = st[k-1].bx_rem[SLICE_W-1:0];
            assign sc     = st[k-1].carry;
            assign nxt[k] = '{valid:  st[k-1].valid,
                              res:    st[k-1].res | (MAX_W'(ss) << (SLICE_W * k)),
                              a_rem:  st[k-1].a_rem >> SLICE_W,
                              bx_rem: st[k-1].bx_rem >> SLICE_W,
                              carry:  sco,
                              c_msb:  scm};
        end

        cla_slice4 u_slice (
            .a     (sa),
            .b     (sb),
            .cin   (sc),
            .s     (ss),
            .cout  (sco),
            .c_msb (scm)
        );
    end

    // NOTE: state registers use non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only the valid bits need reset; the datapath is cleared too so outputs read 0 under reset.
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) st[k] <= nxt[k];
            end
        end
    end

    assign out_valid = st[LAST].valid;
    assign s         = st[LAST].res[WIDTH-1:0];
    assign cout      = st[LAST].carry;
    assign ovf       = st[LAST].carry ^ st[LAST].c_msb;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16): directed corner cases, backpressure,
// mid-flight reset, and a long random run against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             op = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_emit = 0;
    logic last_acc = 1'b0;
    logic last_emit = 1'b0;
    logic [WIDTH+1:0] exp_q [$];

    addsub_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, result packed as {s, cout, ovf}.
    function automatic logic [WIDTH+1:0] ref_fn(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                input logic rop);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] rs;
        logic             rc, ro;
        if (!rop) begin
            wide = {1'b0, ra} + {1'b0, rb};
            rs   = wide[WIDTH-1:0];
            rc   = wide[WIDTH];
            ro   = (ra[WIDTH-1] == rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]);
        end else begin
            wide = {1'b0, ra} - {1'b0, rb};
            rs   = wide[WIDTH-1:0];
            rc   = (ra >= rb);
            ro   = (ra[WIDTH-1] != rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]);
        end
        return {rs, rc, ro};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes at the falling edge, score outputs, return 1 time unit after the rising edge.
    task automatic step();
        logic             acc, emt;
        logic [WIDTH+1:0] obs, expv;
        @(negedge clk);
        acc = in_valid && in_ready;
        emt = out_valid && out_ready;
        obs = {s, cout, ovf};
        if (emt) begin
            n_emit++;
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'(obs), 32'hDEAD_BEEF);
            end else begin
                expv = exp_q.pop_front();
                chk("scoreboard", 32'(obs), 32'(expv));
            end
        end
        if (acc) begin
            n_acc++;
            exp_q.push_back(ref_fn(a, b, op));
        end
        last_acc  = acc;
        last_emit = emt;
        @(posedge clk);
        #1;
    endtask

    // Single operation into an idle pipe: checks acceptance, latency and the spec's result values.
    task automatic run_one(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic top, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int g;
        int lat;
        out_ready = 1'b1;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        g = 0;
        step();
        while (!last_acc && g < 20) begin
            step();
            g++;
        end
        chk({tag, "_accept"}, 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(STAGES));
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        step();
    endtask

    initial begin
        logic [WIDTH-1:0] bp_a [6];
        logic [WIDTH-1:0] bp_b [6];
        logic             bp_op [6];
        logic [WIDTH+1:0] first_exp;
        int idx, acc0, emit0, issued, cyc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        run_one("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_borrow",16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_one("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: six back-to-back operations against a stalled consumer
        for (int i = 0; i < 6; i++) begin
            bp_a[i]  = 16'($urandom);
            bp_b[i]  = 16'($urandom);
            bp_op[i] = 1'($urandom);
        end
        first_exp = ref_fn(bp_a[0], bp_b[0], bp_op[0]);
        out_ready = 1'b0;
        acc0 = n_acc;
        idx = 0;
        a = bp_a[0]; b = bp_b[0]; op = bp_op[0]; in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (last_acc) begin
                idx++;
                if (idx < 6) begin
                    a = bp_a[idx]; b = bp_b[idx]; op = bp_op[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_accepted", 32'(n_acc - acc0), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_s", 32'(s), 32'(first_exp[WIDTH+1:2]));
        out_ready = 1'b1;
        emit0 = n_emit;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("bp_consecutive", 32'(last_emit), 32'd1);
            if (last_acc) begin
                idx++;
                if (idx < 6) begin
                    a = bp_a[idx]; b = bp_b[idx]; op = bp_op[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_emitted", 32'(n_emit - emit0), 32'd6);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        run_one("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random traffic with random producer and consumer stalls
        issued = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (issued < 10000 && cyc < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) begin
                issued++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        chk("rand_issued", 32'(issued), 32'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_idle_out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
